sequence_checker: RTL and testbench
===================================

# sequence_checker

Memory-game sequence engine that consumes the 0–9 digit stream from the random digit generator. Each round it appends one digit to a stored sequence and plays the whole sequence back for the display. It then checks the player's key entries against the stored sequence digit by digit. It sits between the random digit generator, the keypad debouncer and the 7-segment driver, and reports pass/fail per round.

## Interface
Parameters:
- DEPTH, 8, maximum sequence length (1..15)
- SHOW_CYCLES, 4, clock cycles each digit is displayed during playback (≥1)

Ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- rnd  input  4  current random digit, 0–9; sampled only on an accepted start.
- start  input  1  single-cycle pulse requesting a new round.
- key_valid  input  1  single-cycle strobe marking a player key press.
- key  input  4  player digit; qualified by key_valid.
- show_digit  output  4  digit to display; valid while show_valid=1.
- show_valid  output  1  playback digit present.
- busy  output  1  high in every state except IDLE.
- level  output  4  current stored sequence length.
- pass  output  1  one-cycle pulse: round entered correctly.
- fail  output  1  one-cycle pulse: wrong key entered.

## Operation
- Storage: buf[0..DEPTH-1] of 4-bit digits; len counter 0..DEPTH; idx pointer; show timer 0..SHOW_CYCLES-1. All outputs are registered.
- States: IDLE, SHOW, GAP, INPUT.
- IDLE, start=1:
  - If len<DEPTH: buf[len]<=rnd, len<=len+1.
  - If len==DEPTH, the game restarts: buf[0]<=rnd, len<=1.
  - Then idx<=0, timer<=0, go to SHOW.
- SHOW: show_valid=1, show_digit=buf[idx]. Timer counts to SHOW_CYCLES-1, then go to GAP.
- GAP: show_valid=0 for exactly 1 cycle.
  - If idx==len-1: idx<=0, go to INPUT.
  - Otherwise idx<=idx+1, timer<=0, go to SHOW.
- INPUT, key_valid=1:
  - key==buf[idx] and idx==len-1: pass pulse, go to IDLE.
  - key==buf[idx] and idx<len-1: idx<=idx+1.
  - key!=buf[idx]: fail pulse, len<=0, go to IDLE.
  - Keys 10–15 never match, so they give fail.
- Ignored events:
  - start outside IDLE.
  - key_valid outside INPUT.
  - start and key_valid in the same cycle: only the event legal for the current state is acted on.
- level = len. It updates on an accepted start and clears on fail.
- The rnd value is never range-checked; the generator guarantees 0–9.

## Timing
- Reset (synchronous, highest priority, any state including mid-playback or mid-input):
  - Next cycle: state IDLE, len=0, idx=0, timer=0.
  - Outputs show_digit=0, show_valid=0, busy=0, level=0, pass=0, fail=0.
  - buf contents are undefined after reset and are never read before being written.
- start sampled at edge k:
  - From cycle k+1: busy=1, level=len+1, show_valid=1 with show_digit=buf[0].
  - Each digit occupies SHOW_CYCLES cycles of show_valid=1 followed by 1 cycle of show_valid=0.
  - Playback length is len×(SHOW_CYCLES+1) cycles; INPUT is entered the cycle after the last gap.
- key_valid sampled at edge m in INPUT:
  - pass/fail high during cycle m+1 only.
  - busy=0 in the same cycle m+1.
  - A new start is accepted at edge m+1 at the earliest.
- Back-to-back key_valid on consecutive cycles is legal; each strobe is checked against successive idx values.

## Test plan
Bench uses DEPTH=4, SHOW_CYCLES=2.
- Reset, then idle 5 cycles -> all outputs 0, level=0, busy=0.
- rnd=7, start pulse -> show_valid=1 with show_digit=7 for 2 cycles, then 0 for 1 cycle, level=1; key_valid with key=7 -> pass one cycle, busy=0.
- Continue with rnd=3, start -> playback 7,7,gap,3,3,gap; keys 7 then 3 on consecutive cycles -> pass, level=2. Key 7 with key_valid during playback -> ignored, no pass/fail.
- Sequence 7,3,1: enter keys 7,5 -> fail one cycle after the 5, level=0, busy=0; the next start yields level=1 with the new rnd; key=12 in INPUT -> fail.
- Four consecutive passed rounds (level=4), then start with rnd=9 -> level=1, single playback digit 9.
- Assert reset during SHOW and again during INPUT -> next cycle all outputs 0 and state IDLE; start during INPUT -> ignored, level unchanged.

Source files
------------

// File: rtl/sequence_checker.sv
// Memory-game engine: each round appends a random digit, plays the stored sequence back, then checks keys.
// All outputs are registered from next-state values, so they change on the same edge as the state.
module sequence_checker #(
  parameter int DEPTH       = 8,
  parameter int SHOW_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rnd,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] show_digit,
  output logic       show_valid,
  output logic       busy,
  output logic [3:0] level,
  output logic       pass,
  output logic       fail
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [3:0]    DEPTH_L    = 4'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SHOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, INPUT} state_t;

  state_t        state, state_next;
  logic [3:0]    digits [DEPTH];
  logic [3:0]    len, len_next;
  logic [3:0]    idx, idx_next;
  logic [TW-1:0] timer, timer_next;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic          last_idx;
  logic          key_match;

  logic [3:0]    show_digit_next;
  logic          show_valid_next;
  logic          busy_next;
  logic          pass_next;
  logic          fail_next;

  assign last_idx  = (idx == len - 4'd1);
  // Keys above 9 are rejected explicitly so a stray stored value can never make them match.
  assign key_match = (key <= 4'd9) && (key == digits[idx[AW-1:0]]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len   <= '0;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_next;
      len   <= len_next;
      idx   <= idx_next;
      timer <= timer_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      digits[wr_addr[AW-1:0]] <= rnd;
    end
  end

  always_comb begin
    state_next = state;
    len_next   = len;
    idx_next   = idx;
    timer_next = timer;
    wr_en      = 1'b0;
    wr_addr    = len;
    pass_next  = 1'b0;
    fail_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          wr_en = 1'b1;
          if (len == DEPTH_L) begin
            wr_addr  = 4'd0;
            len_next = 4'd1;
          end else begin
            wr_addr  = len;
            len_next = len + 4'd1;
          end
          idx_next   = '0;
          timer_next = '0;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (timer == TIMER_LAST) begin
          state_next = GAP;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      GAP: begin
        if (last_idx) begin
          idx_next   = '0;
          state_next = INPUT;
        end else begin
          idx_next   = idx + 4'd1;
          timer_next = '0;
          state_next = SHOW;
        end
      end
      INPUT: begin
        if (key_valid) begin
          if (!key_match) begin
            fail_next  = 1'b1;
            len_next   = '0;
            state_next = IDLE;
          end else if (last_idx) begin
            pass_next  = 1'b1;
            state_next = IDLE;
          end else begin
            idx_next = idx + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A digit written on this edge is not yet in storage, so forward it to the display.
  always_comb begin
    show_valid_next = (state_next == SHOW);
    busy_next       = (state_next != IDLE);
    show_digit_next = 4'd0;
    if (show_valid_next) begin
      if (wr_en && (wr_addr == idx_next)) begin
        show_digit_next = rnd;
      end else begin
        show_digit_next = digits[idx_next[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      show_digit <= '0;
      show_valid <= 1'b0;
      busy       <= 1'b0;
      level      <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      show_digit <= show_digit_next;
      show_valid <= show_valid_next;
      busy       <= busy_next;
      level      <= len_next;
      pass       <= pass_next;
      fail       <= fail_next;
    end
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Randomized bench for sequence_checker; expectations come from a queue model of the stored sequence.
module tb_sequence_checker;

  localparam int DEPTH = 4;
  localparam int SC    = 2;

  typedef logic [3:0] dq_t[$];

  logic       clk = 1'b0;
  logic       reset, start, key_valid;
  logic [3:0] rnd, key;
  logic [3:0] show_digit, level;
  logic       show_valid, busy, pass, fail;

  int   total = 0;
  int   bad   = 0;
  dq_t  mq;

  always #5 clk = ~clk;

  sequence_checker #(.DEPTH(DEPTH), .SHOW_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .rnd(rnd), .start(start),
    .key_valid(key_valid), .key(key),
    .show_digit(show_digit), .show_valid(show_valid), .busy(busy),
    .level(level), .pass(pass), .fail(fail)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; key_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic do_start(input logic [3:0] r, input string nm);
    if (mq.size() == DEPTH) mq.delete();
    mq.push_back(r);
    rnd = r; start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({busy, level} !== {1'b1, 4'(mq.size())}) begin
      bad++;
      $display("FAIL %s start: busy/level got %b/%0d want 1/%0d", nm, busy, level, mq.size());
    end
  endtask

  // Walks the whole playback; optionally pokes a key that must be ignored.
  task automatic do_playback(input string nm, input bit poke);
    for (int i = 0; i < mq.size(); i++) begin
      for (int c = 0; c < SC; c++) begin
        total++;
        if ({show_valid, show_digit, busy, level} !== {1'b1, mq[i], 1'b1, 4'(mq.size())}) begin
          bad++;
          $display("FAIL %s show d%0d c%0d: got v=%b d=%0d b=%b l=%0d want v=1 d=%0d l=%0d",
                   nm, i, c, show_valid, show_digit, busy, level, mq[i], mq.size());
        end
        if (poke && i == 0 && c == 0) begin
          key_valid = 1'b1; key = mq[0];
        end
        step();
        key_valid = 1'b0;
        total++;
        if ({pass, fail} !== 2'b00) begin
          bad++;
          $display("FAIL %s show_pf d%0d: got %b%b want 00", nm, i, pass, fail);
        end
      end
      total++;
      if ({show_valid, show_digit, busy} !== {1'b0, 4'd0, 1'b1}) begin
        bad++;
        $display("FAIL %s gap d%0d: got v=%b d=%0d b=%b want 0 0 1", nm, i, show_valid, show_digit, busy);
      end
      step();
    end
    total++;
    if ({show_valid, busy, pass, fail} !== 4'b0100) begin
      bad++;
      $display("FAIL %s input_entry: got v=%b b=%b p=%b f=%b want 0 1 0 0", nm, show_valid, busy, pass, fail);
    end
  endtask

  // Keys go in back-to-back; random starts alongside them must be ignored.
  task automatic do_keys(input dq_t ks, input string nm);
    int n;
    bit done, mis, exp_pass;
    n = mq.size();
    done = 1'b0;
    for (int i = 0; i < ks.size() && !done; i++) begin
      key = ks[i]; key_valid = 1'b1;
      start = 1'($urandom_range(0, 1)); rnd = 4'($urandom_range(0, 9));
      step();
      key_valid = 1'b0; start = 1'b0;
      mis      = (ks[i] > 4'd9) || (ks[i] != mq[i]);
      exp_pass = !mis && (i == n - 1);
      total++;
      if ({pass, fail} !== {exp_pass, mis}) begin
        bad++;
        $display("FAIL %s key%0d=%0d pass/fail: got %b%b want %b%b", nm, i, ks[i], pass, fail, exp_pass, mis);
      end
      if (mis || exp_pass) begin
        done = 1'b1;
        if (mis) mq.delete();
        total++;
        if ({busy, level} !== {1'b0, 4'(mq.size())}) begin
          bad++;
          $display("FAIL %s end busy/level: got %b/%0d want 0/%0d", nm, busy, level, mq.size());
        end
      end
    end
    step();
    total++;
    if ({pass, fail, busy} !== 3'b000) begin
      bad++;
      $display("FAIL %s after: got p=%b f=%b b=%b want 0 0 0", nm, pass, fail, busy);
    end
  endtask

  task automatic test_reset();
    rnd = 4'd0; key = 4'd0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({show_digit, show_valid, busy, level, pass, fail} !== 12'h000) begin
        bad++;
        $display("FAIL reset idle%0d: got %h want 000", i,
                 {show_digit, show_valid, busy, level, pass, fail});
      end
    end
  endtask

  task automatic test_first_round();
    do_start(4'd7, "first");
    do_playback("first", 1'b0);
    do_keys('{4'd7}, "first");
  endtask

  task automatic test_back_to_back();
    do_start(4'd3, "b2b");
    do_playback("b2b", 1'b1);
    do_keys('{4'd7, 4'd3}, "b2b");
    total++;
    if (level !== 4'd2) begin
      bad++;
      $display("FAIL b2b level: got %0d want 2", level);
    end
  endtask

  task automatic test_fail();
    do_start(4'd1, "fail");
    do_playback("fail", 1'b0);
    do_keys('{4'd7, 4'd5}, "fail");
    do_start(4'($urandom_range(0, 9)), "fail_restart");
    do_playback("fail_restart", 1'b0);
    do_keys('{4'd12}, "fail_key12");
  endtask

  task automatic test_wrap();
    dq_t ks;
    do_reset();
    for (int r = 0; r < DEPTH; r++) begin
      do_start(4'($urandom_range(0, 9)), "wrap");
      do_playback("wrap", 1'b0);
      ks = mq;
      do_keys(ks, "wrap");
    end
    total++;
    if (level !== 4'(DEPTH)) begin
      bad++;
      $display("FAIL wrap full level: got %0d want %0d", level, DEPTH);
    end
    do_start(4'd9, "wrap9");
    do_playback("wrap9", 1'b0);
    do_keys('{4'd9}, "wrap9");
  endtask

  task automatic test_reset_mid();
    do_start(4'd6, "rst_show");
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    mq.delete();
    total++;
    if ({show_digit, show_valid, busy, level, pass, fail} !== 12'h000) begin
      bad++;
      $display("FAIL rst_show: got %h want 000", {show_digit, show_valid, busy, level, pass, fail});
    end
    do_start(4'd2, "rst_input");
    do_playback("rst_input", 1'b0);
    rnd = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({busy, level, show_valid} !== {1'b1, 4'd1, 1'b0}) begin
      bad++;
      $display("FAIL start_in_input: got b=%b l=%0d v=%b want 1 1 0", busy, level, show_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    mq.delete();
    total++;
    if ({show_digit, show_valid, busy, level, pass, fail} !== 12'h000) begin
      bad++;
      $display("FAIL rst_input: got %h want 000", {show_digit, show_valid, busy, level, pass, fail});
    end
    do_start(4'd4, "post_rst");
    do_playback("post_rst", 1'b0);
    do_keys('{4'd4}, "post_rst");
  endtask

  task automatic test_random();
    dq_t ks;
    logic [3:0] k;
    for (int r = 0; r < 30; r++) begin
      do_start(4'($urandom_range(0, 9)), "rand");
      do_playback("rand", 1'($urandom_range(0, 1)));
      ks.delete();
      for (int i = 0; i < mq.size(); i++) begin
        k = ($urandom_range(0, 9) < 8) ? mq[i] : 4'($urandom_range(0, 15));
        ks.push_back(k);
        if (k != mq[i]) break;
      end
      do_keys(ks, "rand");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_valid = 1'b0; rnd = 4'd0; key = 4'd0;
    test_reset();
    test_first_round();
    test_back_to_back();
    test_fail();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
